// File: rtl/accum_bank_if.sv
// Request/response bundle for accum_bank: clear, per-column write and read
// requests, packed read results, sticky overflow flags and the busy indication.
// master = requester side, slave = accum_bank side.
interface accum_bank_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int DEPTH      = 1024,
   parameter int NUM_COLS   = 16
);
   localparam int AW = $clog2(DEPTH);

   logic                           clear;
   logic [NUM_COLS-1:0]            wr_en;
   logic [NUM_COLS-1:0]            wr_mode;
   logic [AW*NUM_COLS-1:0]         wr_addr;
   logic [DATA_WIDTH*NUM_COLS-1:0] wr_data;
   logic [NUM_COLS-1:0]            rd_en;
   logic [AW*NUM_COLS-1:0]         rd_addr;
   logic [ACC_WIDTH*NUM_COLS-1:0]  rd_data;
   logic [NUM_COLS-1:0]            rd_valid;
   logic [NUM_COLS-1:0]            ovf;
   logic                           busy;

   modport master (
      output clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid, ovf, busy
   );

   modport slave (
      input  clear, wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid, ovf, busy
   );
endinterface

// File: rtl/accum_bank.sv
// Bank of NUM_COLS independent signed accumulator tables with a zeroing sweep.
// Latency: write commits at end of the cycle after acceptance; read data 1 cycle.
// Backpressure: none; requests are ignored while busy or while clear is high.
// Ports: clk; rst_n (async, active-low); bus (slave modport) carrying clear,
// per-column wr_en/wr_mode/wr_addr/wr_data, rd_en/rd_addr, rd_data/rd_valid,
// sticky per-column ovf and busy.
module accum_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int DEPTH      = 1024,
   parameter int NUM_COLS   = 16,
   parameter int SATURATE   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   accum_bank_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   localparam logic [AW-1:0]        LAST_ROW = AW'(DEPTH - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   // Table storage; not reset, the post-reset sweep zeroes it.
   logic [ACC_WIDTH-1:0] mem [NUM_COLS][DEPTH];

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] sweep_row;
   logic          sweep_en;
   logic          accept;

   // Writes are registered for one cycle, then read-modify-written. The
   // table read happens in the commit cycle, so the previous write is already
   // in the array and back-to-back accumulates need no bypass path.
   logic [NUM_COLS-1:0]            pend_vld_q,  pend_vld_d;
   logic [NUM_COLS-1:0]            pend_mode_q, pend_mode_d;
   logic [AW*NUM_COLS-1:0]         pend_addr_q, pend_addr_d;
   logic [DATA_WIDTH*NUM_COLS-1:0] pend_dat_q,  pend_dat_d;

   logic [ACC_WIDTH*NUM_COLS-1:0]  rd_data_q,  rd_data_d;
   logic [NUM_COLS-1:0]            rd_valid_q, rd_valid_d;
   logic [NUM_COLS-1:0]            ovf_q,      ovf_d;
   logic [ACC_WIDTH*NUM_COLS-1:0]  new_val;

   logic signed [DATA_WIDTH-1:0] din;
   logic signed [ACC_WIDTH-1:0]  ext;
   logic signed [ACC_WIDTH-1:0]  old;
   logic signed [ACC_WIDTH:0]    sum;
   logic [ACC_WIDTH-1:0]         res;
   logic                         ovfl;

   // Control FSM. A clear during a sweep restarts it in the same cycle, so
   // that cycle already zeroes row 0.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sweep_row = cnt_q;
      sweep_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clear) begin
               state_d = ST_SWEEP;
               cnt_d   = '0;
            end
         end
         default: begin
            sweep_en  = 1'b1;
            sweep_row = bus.clear ? '0 : cnt_q;
            cnt_d     = sweep_row + AW'(1);
            if (sweep_row == LAST_ROW) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Requests coinciding with clear are dropped so nothing lands or returns
   // once the sweep is under way.
   assign accept = (state_q == ST_IDLE) && !bus.clear;

   always_comb begin
      pend_vld_d  = accept ? bus.wr_en : '0;
      pend_mode_d = bus.wr_mode;
      pend_addr_d = bus.wr_addr;
      pend_dat_d  = bus.wr_data;
      rd_valid_d  = '0;
      rd_data_d   = rd_data_q;
      ovf_d       = ovf_q;
      new_val     = '0;
      din         = '0;
      ext         = '0;
      old         = '0;
      sum         = '0;
      res         = '0;
      ovfl        = 1'b0;
      for (int c = 0; c < NUM_COLS; c++) begin
         din  = pend_dat_q[c*DATA_WIDTH +: DATA_WIDTH];
         ext  = ACC_WIDTH'(din);
         old  = mem[c][pend_addr_q[c*AW +: AW]];
         sum  = (ACC_WIDTH+1)'(old) + (ACC_WIDTH+1)'(ext);
         ovfl = 1'b0;
         if (pend_mode_q[c]) begin
            res = ext;
         end else begin
            res = sum[ACC_WIDTH-1:0];
            // Extra sign bit disagreeing with the result MSB means overflow.
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
               ovfl = 1'b1;
               if (SATURATE != 0) res = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end
         end
         new_val[c*ACC_WIDTH +: ACC_WIDTH] = res;
         if (pend_vld_q[c] && ovfl) ovf_d[c] = 1'b1;
         // Read sees the array before this cycle's commit: pre-write value.
         if (accept && bus.rd_en[c]) begin
            rd_valid_d[c] = 1'b1;
            rd_data_d[c*ACC_WIDTH +: ACC_WIDTH] = mem[c][bus.rd_addr[c*AW +: AW]];
         end
      end
      if (bus.clear) ovf_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SWEEP;
         cnt_q       <= '0;
         pend_vld_q  <= '0;
         pend_mode_q <= '0;
         pend_addr_q <= '0;
         pend_dat_q  <= '0;
         rd_valid_q  <= '0;
         rd_data_q   <= '0;
         ovf_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_vld_q  <= pend_vld_d;
         pend_mode_q <= pend_mode_d;
         pend_addr_q <= pend_addr_d;
         pend_dat_q  <= pend_dat_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         ovf_q       <= ovf_d;
      end
   end

   // Sweep has priority over a pending commit to the same column.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_COLS; c++) begin
         if (sweep_en) begin
            mem[c][sweep_row] <= '0;
         end else if (pend_vld_q[c]) begin
            mem[c][pend_addr_q[c*AW +: AW]] <= new_val[c*ACC_WIDTH +: ACC_WIDTH];
         end
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.ovf      = ovf_q;
   assign bus.busy     = (state_q == ST_SWEEP);
endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: a saturating and a wrapping instance share
// identical stimulus; expected values are hand-computed constants.
module tb_accum_bank;
   localparam int DW    = 16;
   localparam int ACW   = 24;
   localparam int DEPTH = 32;
   localparam int NC    = 4;
   localparam int AW    = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   accum_bank_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACW), .DEPTH(DEPTH), .NUM_COLS(NC)) bus_s ();
   accum_bank_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACW), .DEPTH(DEPTH), .NUM_COLS(NC)) bus_w ();

   accum_bank #(.DATA_WIDTH(DW), .ACC_WIDTH(ACW), .DEPTH(DEPTH), .NUM_COLS(NC), .SATURATE(1))
      dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
   accum_bank #(.DATA_WIDTH(DW), .ACC_WIDTH(ACW), .DEPTH(DEPTH), .NUM_COLS(NC), .SATURATE(0))
      dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

   assign bus_w.clear   = bus_s.clear;
   assign bus_w.wr_en   = bus_s.wr_en;
   assign bus_w.wr_mode = bus_s.wr_mode;
   assign bus_w.wr_addr = bus_s.wr_addr;
   assign bus_w.wr_data = bus_s.wr_data;
   assign bus_w.rd_en   = bus_s.rd_en;
   assign bus_w.rd_addr = bus_s.rd_addr;

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus_s.clear   = 1'b0;
      bus_s.wr_en   = '0;
      bus_s.wr_mode = '0;
      bus_s.wr_addr = '0;
      bus_s.wr_data = '0;
      bus_s.rd_en   = '0;
      bus_s.rd_addr = '0;
   endtask

   task automatic set_wr(input int c, input logic [AW-1:0] a, input logic m, input logic [DW-1:0] d);
      bus_s.wr_en[c]              = 1'b1;
      bus_s.wr_mode[c]            = m;
      bus_s.wr_addr[c*AW +: AW]   = a;
      bus_s.wr_data[c*DW +: DW]   = d;
   endtask

   task automatic set_rd(input int c, input logic [AW-1:0] a);
      bus_s.rd_en[c]            = 1'b1;
      bus_s.rd_addr[c*AW +: AW] = a;
   endtask

   function automatic logic [ACW-1:0] col(input logic [ACW*NC-1:0] v, input int c);
      return v[c*ACW +: ACW];
   endfunction

   task automatic wait_sweep(output int n);
      n = 0;
      while (bus_s.busy && n < 4*DEPTH) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rv;
      logic [AW-1:0] addrs [9];
      addrs = '{5'd2, 5'd5, 5'd9, 5'd3, 5'd17, 5'd12, 5'd13, 5'd31, 5'd0};

      // Reset: outputs forced immediately, then a DEPTH-cycle sweep.
      idle_in();
      #1 rst_n = 1'b0;
      #2;
      chk_eq("rst_busy", bus_s.busy, 1'b1);
      chk_eq("rst_vld", bus_s.rd_valid, 4'h0);
      chk_eq("rst_ovf", bus_s.ovf, 4'h0);
      chk_eq("rst_rdat", bus_s.rd_data, '0);
      tick(); tick();
      rst_n = 1'b1;
      wait_sweep(n);
      chk_eq("rst_sweep_len", n, DEPTH);

      // Read after sweep returns zero with one-cycle latency.
      set_rd(2, 5'd7); set_rd(0, 5'd31);
      tick(); idle_in();
      chk_eq("rd0_vld", bus_s.rd_valid, 4'b0101);
      chk_eq("rd0_c2", col(bus_s.rd_data, 2), 24'h0);
      chk_eq("rd0_c0", col(bus_s.rd_data, 0), 24'h0);
      tick();
      chk_eq("rd0_vld_drop", bus_s.rd_valid, 4'h0);

      // Back-to-back accumulate 100 then -30 on col 3 addr 5, read at T+3.
      set_wr(3, 5'd5, 1'b0, 16'd100); tick();
      idle_in(); set_wr(3, 5'd5, 1'b0, -16'sd30); tick();
      idle_in(); tick();
      set_rd(3, 5'd5); set_rd(2, 5'd5); tick(); idle_in();
      chk_eq("acc_c3", col(bus_s.rd_data, 3), 24'd70);
      chk_eq("acc_c2_untouched", col(bus_s.rd_data, 2), 24'h0);
      chk_eq("acc_vld", bus_s.rd_valid, 4'b1100);

      // Read/write same address same cycle: old value, then new.
      set_wr(2, 5'd12, 1'b1, 16'd40); tick();
      idle_in(); tick(); tick();
      set_wr(2, 5'd12, 1'b1, 16'd7); set_rd(2, 5'd12); tick(); idle_in();
      chk_eq("rw_old_vld", bus_s.rd_valid, 4'b0100);
      chk_eq("rw_old_dat", col(bus_s.rd_data, 2), 24'd40);
      tick();
      chk_eq("rw_gap_vld", bus_s.rd_valid, 4'h0);
      chk_eq("rw_gap_hold", col(bus_s.rd_data, 2), 24'd40);
      set_rd(2, 5'd12); tick(); idle_in();
      chk_eq("rw_new_vld", bus_s.rd_valid, 4'b0100);
      chk_eq("rw_new_dat", col(bus_s.rd_data, 2), 24'd7);
      tick();
      chk_eq("rw_end_vld", bus_s.rd_valid, 4'h0);

      // A read one cycle after a write must not see it; two cycles after must.
      set_wr(1, 5'd13, 1'b1, 16'd9); tick();
      idle_in(); set_rd(1, 5'd13); tick(); idle_in();
      chk_eq("rd_excl", col(bus_s.rd_data, 1), 24'h0);
      set_rd(1, 5'd13); tick(); idle_in();
      chk_eq("rd_incl", col(bus_s.rd_data, 1), 24'd9);

      // Sign extension: overwrite -5, accumulate +2 -> -3.
      set_wr(0, 5'd3, 1'b1, 16'hFFFB); tick();
      idle_in(); set_wr(0, 5'd3, 1'b0, 16'd2); tick();
      idle_in(); tick();
      set_rd(0, 5'd3); tick(); idle_in();
      chk_eq("sext", col(bus_s.rd_data, 0), 24'hFFFFFD);
      chk_eq("ovf_none", bus_s.ovf, 4'h0);

      // Positive overflow on col 1 addr 9: build 0x7FFFF0, then add 0x100.
      for (int i = 0; i < 256; i++) begin
         set_wr(1, 5'd9, 1'b0, 16'h7FFF); tick();
      end
      set_wr(1, 5'd9, 1'b0, 16'h00F0); tick();
      idle_in(); tick();
      set_rd(1, 5'd9); tick(); idle_in();
      chk_eq("near_max", col(bus_s.rd_data, 1), 24'h7FFFF0);
      chk_eq("near_max_ovf", bus_s.ovf, 4'h0);
      set_wr(1, 5'd9, 1'b0, 16'h0100); tick();
      idle_in(); tick();
      set_rd(1, 5'd9); tick(); idle_in();
      chk_eq("sat_pos", col(bus_s.rd_data, 1), 24'h7FFFFF);
      chk_eq("wrap_pos", col(bus_w.rd_data, 1), 24'h8000F0);
      chk_eq("sat_pos_ovf", bus_s.ovf, 4'b0010);
      chk_eq("wrap_pos_ovf", bus_w.ovf, 4'b0010);

      // Negative: reach exactly the minimum without overflow, then step below.
      for (int i = 0; i < 256; i++) begin
         set_wr(0, 5'd17, 1'b0, 16'h8000); tick();
      end
      idle_in(); tick();
      set_rd(0, 5'd17); tick(); idle_in();
      chk_eq("at_min", col(bus_s.rd_data, 0), 24'h800000);
      chk_eq("at_min_ovf", bus_s.ovf, 4'b0010);
      set_wr(0, 5'd17, 1'b0, 16'hFFFF); tick();
      idle_in(); tick();
      set_rd(0, 5'd17); tick(); idle_in();
      chk_eq("sat_neg", col(bus_s.rd_data, 0), 24'h800000);
      chk_eq("wrap_neg", col(bus_w.rd_data, 0), 24'h7FFFFF);
      chk_eq("sat_neg_ovf", bus_s.ovf, 4'b0011);
      chk_eq("wrap_neg_ovf", bus_w.ovf, 4'b0011);

      // Clear mid-stream with all requests held high, restarted at row 10.
      for (int c = 0; c < NC; c++) begin
         set_wr(c, 5'd2, 1'b0, 16'd1);
         set_rd(c, 5'd2);
      end
      tick(); tick(); tick();
      chk_eq("pre_clr_vld", bus_s.rd_valid, 4'hF);
      bus_s.clear = 1'b1;
      tick();
      bus_s.clear = 1'b0;
      chk_eq("clr_ovf_s", bus_s.ovf, 4'h0);
      chk_eq("clr_ovf_w", bus_w.ovf, 4'h0);
      n  = 0;
      rv = 0;
      while (bus_s.busy && n < 4*DEPTH) begin
         if (|bus_s.rd_valid) rv++;
         if (n == 10) bus_s.clear = 1'b1;
         tick();
         bus_s.clear = 1'b0;
         n++;
      end
      idle_in();
      chk_eq("clr_busy_len", n, 10 + DEPTH);
      chk_eq("clr_no_vld", rv, 0);
      for (int k = 0; k < 9; k++) begin
         for (int c = 0; c < NC; c++) set_rd(c, addrs[k]);
         tick(); idle_in();
         chk_eq("post_clr_vld", bus_s.rd_valid, 4'hF);
         chk_eq("post_clr_dat", bus_s.rd_data, '0);
      end
      chk_eq("post_clr_ovf", bus_s.ovf, 4'h0);

      // Reset one cycle after an accepted write: async effect, write dropped.
      set_wr(2, 5'd12, 1'b1, 16'd7); tick();
      idle_in(); tick();
      set_wr(1, 5'd20, 1'b1, 16'h0055); set_rd(2, 5'd12); tick(); idle_in();
      chk_eq("pre_rst_vld", bus_s.rd_valid, 4'b0100);
      chk_eq("pre_rst_dat", col(bus_s.rd_data, 2), 24'd7);
      rst_n = 1'b0;
      #2;
      chk_eq("arst_busy", bus_s.busy, 1'b1);
      chk_eq("arst_vld", bus_s.rd_valid, 4'h0);
      chk_eq("arst_dat", bus_s.rd_data, '0);
      chk_eq("arst_ovf", bus_s.ovf, 4'h0);
      tick(); tick();
      rst_n = 1'b1;
      wait_sweep(n);
      chk_eq("arst_sweep_len", n, DEPTH);
      set_rd(1, 5'd20); set_rd(2, 5'd12); tick(); idle_in();
      chk_eq("arst_drop_vld", bus_s.rd_valid, 4'b0110);
      chk_eq("arst_drop_c1", col(bus_s.rd_data, 1), 24'h0);
      chk_eq("arst_drop_c2", col(bus_s.rd_data, 2), 24'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
